// File: rtl/riscv_regfile_mp.sv
// rtl/riscv_regfile_mp.sv - multi-read-port register file with post-reset zero scrub
// Optional write-to-read forwarding is enabled by defining RISCV_RF_BYPASS_EN.

module riscv_regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rf_wr_en_i,
    input  logic [AW-1:0]       rf_wr_addr_i,
    input  logic [XLEN-1:0]     rf_wr_data_i,
    input  logic [NRD*AW-1:0]   rf_rd_addr_i,
    output logic [NRD*XLEN-1:0] rf_rd_data_o,
    output logic                rf_ready_o,
    output logic                rf_wr_drop_o
);

    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW:0]       r_scrub_cnt;
    logic              r_wr_drop;
    logic [XLEN-1:0]   r_regs [NREGS];

    logic              w_scrub_last;
    logic              w_ready;
    logic              w_wr_commit;

    assign w_scrub_last = (r_scrub_cnt == (AW+1)'(NREGS - 1));
    assign w_ready      = (r_state == ST_READY);
    assign w_wr_commit  = w_ready && rf_wr_en_i && (rf_wr_addr_i != '0);

    // Counter is one bit wider than an index so reaching NREGS never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SCRUB;
            r_scrub_cnt <= '0;
            r_wr_drop   <= 1'b0;
        end else begin
            case (r_state)
                ST_SCRUB: begin
                    r_wr_drop   <= rf_wr_en_i;
                    r_scrub_cnt <= r_scrub_cnt + 1'b1;
                    if (w_scrub_last) begin
                        r_state <= ST_READY;
                    end
                end
                ST_READY: begin
                    r_wr_drop <= 1'b0;
                end
                default: begin
                    r_state   <= ST_SCRUB;
                    r_wr_drop <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_SCRUB) begin
                r_regs[r_scrub_cnt[AW-1:0]] <= '0;
            end else if (w_wr_commit) begin
                r_regs[rf_wr_addr_i] <= rf_wr_data_i;
            end
        end
    end

    assign rf_ready_o   = w_ready;
    assign rf_wr_drop_o = r_wr_drop;

    genvar k;
    generate
        for (k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] w_addr;
            logic          w_valid;
            assign w_addr  = rf_rd_addr_i[k*AW +: AW];
            assign w_valid = w_ready && (w_addr != '0);
`ifdef RISCV_RF_BYPASS_EN
            logic w_fwd;
            assign w_fwd = w_wr_commit && (rf_wr_addr_i == w_addr);
            assign rf_rd_data_o[k*XLEN +: XLEN] = !w_valid ? '0 :
                                                  w_fwd    ? rf_wr_data_i :
                                                             r_regs[w_addr];
`else
            assign rf_rd_data_o[k*XLEN +: XLEN] = w_valid ? r_regs[w_addr] : '0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// tb/tb_riscv_regfile_mp.sv - randomized self-checking bench for riscv_regfile_mp
// Expectations for same-cycle reads follow RISCV_RF_BYPASS_EN when it is defined.

module tb_riscv_regfile_mp;

    localparam int NREGS = 32;
    localparam int XLEN  = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [9:0]   ra;
    logic [63:0]  rd;
    logic         ready;
    logic         drop;

    logic         reset2;
    logic         we2;
    logic [3:0]   wa2;
    logic [63:0]  wd2;
    logic [15:0]  ra2;
    logic [255:0] rd2;
    logic         ready2;
    logic         drop2;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [NREGS];
    int          m_edges;
    bit          m_drop;

    always #5 clk = ~clk;

    riscv_regfile_mp u_dut (
        .clk          (clk),
        .reset        (reset),
        .rf_wr_en_i   (we),
        .rf_wr_addr_i (wa),
        .rf_wr_data_i (wd),
        .rf_rd_addr_i (ra),
        .rf_rd_data_o (rd),
        .rf_ready_o   (ready),
        .rf_wr_drop_o (drop)
    );

    riscv_regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4)) u_dut_wide (
        .clk          (clk),
        .reset        (reset2),
        .rf_wr_en_i   (we2),
        .rf_wr_addr_i (wa2),
        .rf_wr_data_i (wd2),
        .rf_rd_addr_i (ra2),
        .rf_rd_data_o (rd2),
        .rf_ready_o   (ready2),
        .rf_wr_drop_o (drop2)
    );

    function automatic bit m_ready();
        return m_edges >= NREGS;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] addr);
        if (!m_ready() || addr == 5'd0) return 32'd0;
`ifdef RISCV_RF_BYPASS_EN
        if (we && wa == addr) return wd;
`endif
        return m_regs[addr];
    endfunction

    // Model: after NREGS non-reset edges the file is ready and fully zeroed.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_edges = 0;
            m_drop  = 1'b0;
        end else if (!m_ready()) begin
            m_drop = we;
            m_edges++;
            if (m_edges == NREGS)
                for (int r = 0; r < NREGS; r++) m_regs[r] = 32'd0;
        end else begin
            m_drop = 1'b0;
            if (we && wa != 5'd0) m_regs[wa] = wd;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
        tick(); tick();
        ra = 10'($urandom);
        #1;
        n_checks++;
        if (ready !== 1'b0 || drop !== 1'b0 || rd !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_state: ready=%b drop=%b rd=%h, expected 0 0 0", ready, drop, rd);
        end
        reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            ra = 10'($urandom);
            #1;
            n_checks++;
            if (ready !== (i >= 33)) begin
                n_errors++;
                $display("FAIL scrub_ready cycle %0d: got %b expected %b", i, ready, (i >= 33));
            end
            n_checks++;
            if (rd !== 64'd0 || drop !== 1'b0) begin
                n_errors++;
                $display("FAIL scrub_reads cycle %0d: rd=%h drop=%b expected 0", i, rd, drop);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = '0;
        tick();
        we = 1'b0; ra = {5'd5, 5'd5};
        #1;
        n_checks++;
        if (rd !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            n_errors++;
            $display("FAIL write_x5: got %h expected %h", rd, {32'hDEADBEEF, 32'hDEADBEEF});
        end
        we = 1'b1; wa = 5'd0; wd = 32'h1234; ra = '0;
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (rd !== 64'd0) begin
            n_errors++;
            $display("FAIL write_x0: got %h expected 0", rd);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] same_exp;
`ifdef RISCV_RF_BYPASS_EN
        same_exp = 32'hA5A5A5A5;
`else
        same_exp = 32'h0;
`endif
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra = {5'd7, 5'd7};
        #1;
        n_checks++;
        if (rd !== {same_exp, same_exp}) begin
            n_errors++;
            $display("FAIL bypass_same_cycle: got %h expected %h", rd, {same_exp, same_exp});
        end
        tick();
        we = 1'b0;
        #1;
        n_checks++;
        if (rd !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
            n_errors++;
            $display("FAIL bypass_next_cycle: got %h expected %h", rd, {32'hA5A5A5A5, 32'hA5A5A5A5});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom);
            wa = 5'($urandom);
            wd = $urandom;
            ra = 10'($urandom);
            if (i % 5 == 0) ra[4:0] = wa;
            #1;
            for (int p = 0; p < 2; p++) begin
                n_checks++;
                if (rd[p*32 +: 32] !== exp_rd(ra[p*5 +: 5])) begin
                    n_errors++;
                    $display("FAIL random_read port %0d addr %0d: got %h expected %h",
                             p, ra[p*5 +: 5], rd[p*32 +: 32], exp_rd(ra[p*5 +: 5]));
                end
            end
            n_checks++;
            if (ready !== 1'b1 || drop !== 1'b0) begin
                n_errors++;
                $display("FAIL random_status: ready=%b drop=%b expected 1 0", ready, drop);
            end
            tick();
        end
        we = 1'b0;
    endtask

    task automatic test_drop();
        int pulses;
        pulses = 0;
        reset = 1'b1; we = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 34; i++) begin
            we = (i == 4); wa = 5'd3; wd = 32'hFF; ra = {5'd3, 5'd3};
            #1;
            if (drop === 1'b1) pulses++;
            n_checks++;
            if (drop !== (i == 5) || drop !== m_drop) begin
                n_errors++;
                $display("FAIL drop_pulse cycle %0d: got %b expected %b", i, drop, (i == 5));
            end
            tick();
        end
        we = 1'b0;
        #1;
        n_checks++;
        if (pulses != 1 || rd !== 64'd0 || ready !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_x3: pulses=%0d rd=%h ready=%b expected 1 0 1", pulses, rd, ready);
        end
    endtask

    task automatic test_reset_mid_scrub();
        for (int r = 1; r < NREGS; r++) begin
            we = 1'b1; wa = 5'(r); wd = $urandom | 32'h1;
            tick();
        end
        we = 1'b0; ra = {5'd31, 5'd1};
        #1;
        n_checks++;
        if (rd !== {m_regs[31], m_regs[1]} || rd[31:0] === 32'd0) begin
            n_errors++;
            $display("FAIL fill_before_reset: got %h expected %h", rd, {m_regs[31], m_regs[1]});
        end
        reset = 1'b1; tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        for (int i = 1; i <= 34; i++) begin
            #1;
            n_checks++;
            if (ready !== (i >= 33)) begin
                n_errors++;
                $display("FAIL rescrub_ready cycle %0d: got %b expected %b", i, ready, (i >= 33));
            end
            tick();
        end
        for (int r = 0; r < NREGS; r += 2) begin
            ra = {5'(r + 1), 5'(r)};
            #1;
            n_checks++;
            if (rd !== 64'd0) begin
                n_errors++;
                $display("FAIL rescrub_zero x%0d/x%0d: got %h expected 0", r, r + 1, rd);
            end
        end
    endtask

    task automatic test_wide();
        logic [63:0] v1, v2;
        logic [255:0] exp;
        v1 = {$urandom, $urandom} | 64'h1;
        v2 = {$urandom, $urandom} | 64'h2;
        reset2 = 1'b1; we2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0;
        tick(); tick();
        reset2 = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            #1;
            n_checks++;
            if (ready2 !== (i >= 17)) begin
                n_errors++;
                $display("FAIL wide_ready cycle %0d: got %b expected %b", i, ready2, (i >= 17));
            end
            tick();
        end
        we2 = 1'b1; wa2 = 4'd1; wd2 = v1; tick();
        wa2 = 4'd2; wd2 = v2; tick();
        we2 = 1'b0; ra2 = {4'd0, 4'd1, 4'd2, 4'd1};
        #1;
        exp = {64'd0, v1, v2, v1};
        n_checks++;
        if (rd2 !== exp || drop2 !== 1'b0) begin
            n_errors++;
            $display("FAIL wide_ports: got %h expected %h", rd2, exp);
        end
    endtask

    initial begin
        reset2 = 1'b1; we2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0;
        m_edges = 0; m_drop = 1'b0;
        for (int r = 0; r < NREGS; r++) m_regs[r] = 32'd0;
        test_reset();
        test_write_read();
        test_bypass();
        test_random();
        test_drop();
        test_reset_mid_scrub();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
